// File: rtl/axis_dense_layer.sv
// AXI-Stream fully-connected layer: buffers one input frame, runs a single time-shared MAC
// over a runtime-loadable weight RAM, and streams OUT_DEPTH saturated (optionally ReLU'd) results.
module axis_dense_layer #(
    parameter int INP_DEPTH         = 8,
    parameter int OUT_DEPTH         = 2,
    parameter int INPUT_DATA_WIDTH  = 32,
    parameter int WEIGHT_WIDTH      = 16,
    parameter int ACC_WIDTH         = INPUT_DATA_WIDTH + WEIGHT_WIDTH + $clog2(INP_DEPTH),
    parameter int OUTPUT_DATA_WIDTH = ACC_WIDTH
) (
    input  logic                                        axi_clk,
    input  logic                                        axi_reset_n,
    input  logic                                        s_axis_valid,
    input  logic signed [INPUT_DATA_WIDTH-1:0]          s_axis_data,
    input  logic                                        s_axis_last,
    output logic                                        s_axis_ready,
    output logic                                        m_axis_valid,
    output logic signed [OUTPUT_DATA_WIDTH-1:0]         m_axis_data,
    output logic                                        m_axis_last,
    input  logic                                        m_axis_ready,
    input  logic                                        w_wr_en,
    input  logic [$clog2(INP_DEPTH*OUT_DEPTH)-1:0]      w_wr_addr,
    input  logic signed [WEIGHT_WIDTH-1:0]              w_wr_data,
    output logic                                        w_wr_ready,
    input  logic                                        cfg_relu,
    output logic                                        busy,
    output logic                                        err_len
);

    localparam int NW = INP_DEPTH * OUT_DEPTH;
    localparam int AW = $clog2(NW);
    localparam int CW = $clog2(INP_DEPTH);
    localparam int RW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int PW = INPUT_DATA_WIDTH + WEIGHT_WIDTH;

    localparam logic [CW-1:0] LAST_COL = CW'(INP_DEPTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(OUT_DEPTH - 1);
    localparam logic [AW-1:0] LAST_MAC = AW'(NW - 1);

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH - OUTPUT_DATA_WIDTH + 1){1'b0}}, {(OUTPUT_DATA_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
        {{(ACC_WIDTH - OUTPUT_DATA_WIDTH + 1){1'b1}}, {(OUTPUT_DATA_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_SEND    = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic                                r_init_q1;
    logic                                r_init_q2;
    logic [CW-1:0]                       r_wr_cnt;
    logic [CW-1:0]                       r_col;
    logic [RW-1:0]                       r_row;
    logic [AW-1:0]                       r_waddr;
    logic [RW-1:0]                       r_rd_cnt;
    logic signed [ACC_WIDTH-1:0]         r_acc;
    logic                                r_relu;
    logic                                r_err;

    logic signed [INPUT_DATA_WIDTH-1:0]  r_samp [INP_DEPTH];
    logic signed [WEIGHT_WIDTH-1:0]      r_wmem [NW];
    logic signed [OUTPUT_DATA_WIDTH-1:0] r_res  [OUT_DEPTH];

    logic                                w_s_hs;
    logic                                w_m_hs;
    logic                                w_frame_done;
    logic                                w_early_last;
    logic                                w_send_done;
    logic                                w_in_compute;
    logic signed [PW-1:0]                w_prod;
    logic signed [ACC_WIDTH-1:0]         w_prod_ext;
    logic signed [ACC_WIDTH-1:0]         w_sum;
    logic signed [ACC_WIDTH-1:0]         w_act;

    function automatic logic signed [OUTPUT_DATA_WIDTH-1:0] sat(
        input logic signed [ACC_WIDTH-1:0] v
    );
        if (v > SAT_MAX) begin
            return SAT_MAX[OUTPUT_DATA_WIDTH-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[OUTPUT_DATA_WIDTH-1:0];
        end else begin
            return v[OUTPUT_DATA_WIDTH-1:0];
        end
    endfunction

    assign w_in_compute = (r_state == S_COMPUTE);
    assign w_s_hs       = s_axis_valid & s_axis_ready;
    assign w_m_hs       = m_axis_valid & m_axis_ready;
    assign w_frame_done = w_s_hs & (r_wr_cnt == LAST_COL);
    assign w_early_last = w_s_hs & s_axis_last & (r_wr_cnt != LAST_COL);
    assign w_send_done  = w_m_hs & (r_rd_cnt == LAST_ROW);

    // Full-precision MAC; the accumulator restarts at column 0 of every row
    assign w_prod     = r_samp[r_col] * r_wmem[r_waddr];
    assign w_prod_ext = w_prod;
    assign w_sum      = ((r_col == '0) ? '0 : r_acc) + w_prod_ext;
    assign w_act      = (r_relu && w_sum[ACC_WIDTH-1]) ? '0 : w_sum;

    assign m_axis_data = r_res[r_rd_cnt];

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LOAD:    if (w_frame_done) w_next = S_COMPUTE;
            S_COMPUTE: if (r_waddr == LAST_MAC) w_next = S_SEND;
            S_SEND:    if (w_send_done) w_next = S_LOAD;
            default:   w_next = S_LOAD;
        endcase
    end

    always_comb begin
        s_axis_ready = 1'b0;
        m_axis_valid = 1'b0;
        m_axis_last  = 1'b0;
        busy         = 1'b1;
        w_wr_ready   = 1'b1;
        case (r_state)
            S_LOAD: begin
                s_axis_ready = r_init_q2;
                busy         = 1'b0;
            end
            S_COMPUTE: begin
                w_wr_ready = 1'b0;
            end
            S_SEND: begin
                m_axis_valid = 1'b1;
                m_axis_last  = (r_rd_cnt == LAST_ROW);
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Input ready is held off for one extra edge after reset release
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_init_q1 <= 1'b0;
            r_init_q2 <= 1'b0;
        end else begin
            r_init_q1 <= 1'b1;
            r_init_q2 <= r_init_q1;
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_wr_cnt <= '0;
            r_err    <= 1'b0;
            r_relu   <= 1'b0;
        end else begin
            r_err <= (w_frame_done & ~s_axis_last) | w_early_last;
            if (w_frame_done || w_early_last) begin
                r_wr_cnt <= '0;
            end else if (w_s_hs) begin
                r_wr_cnt <= r_wr_cnt + 1'b1;
            end
            if (w_frame_done) begin
                r_relu <= cfg_relu;
            end
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_acc   <= '0;
            r_col   <= '0;
            r_row   <= '0;
            r_waddr <= '0;
        end else if (w_in_compute) begin
            r_acc <= w_sum;
            if (r_waddr == LAST_MAC) begin
                r_waddr <= '0;
                r_col   <= '0;
                r_row   <= '0;
            end else begin
                r_waddr <= r_waddr + 1'b1;
                if (r_col == LAST_COL) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            r_rd_cnt <= '0;
        end else if (w_send_done) begin
            r_rd_cnt <= '0;
        end else if (w_m_hs) begin
            r_rd_cnt <= r_rd_cnt + 1'b1;
        end
    end

    // Storage arrays carry no reset; weights must survive a reset
    always_ff @(posedge axi_clk) begin
        if (w_s_hs) begin
            r_samp[r_wr_cnt] <= s_axis_data;
        end
        if (w_in_compute && (r_col == LAST_COL)) begin
            r_res[r_row] <= sat(w_act);
        end
        if (w_wr_en && w_wr_ready) begin
            r_wmem[w_wr_addr] <= w_wr_data;
        end
    end

    assign err_len = r_err;

endmodule

// File: tb/tb_axis_dense_layer.sv
// Directed and randomized bench for axis_dense_layer with a dot-product reference model.
module tb_axis_dense_layer;

    localparam int NI  = 4;
    localparam int NO  = 2;
    localparam int IW  = 8;
    localparam int WW  = 8;
    localparam int ODW = 8;
    localparam int NWT = NI * NO;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic                   s_valid;
    logic signed [IW-1:0]   s_data;
    logic                   s_last;
    logic                   s_ready;
    logic                   m_valid;
    logic signed [ODW-1:0]  m_data;
    logic                   m_last;
    logic                   m_ready;
    logic                   w_en;
    logic [2:0]             w_addr;
    logic signed [WW-1:0]   w_data;
    logic                   w_ready;
    logic                   relu;
    logic                   busy;
    logic                   err_len;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int acc_cyc = 0;
    int wmod [NWT];
    int smod [NI];

    axis_dense_layer #(
        .INP_DEPTH(NI), .OUT_DEPTH(NO), .INPUT_DATA_WIDTH(IW),
        .WEIGHT_WIDTH(WW), .OUTPUT_DATA_WIDTH(ODW)
    ) dut (
        .axi_clk(clk), .axi_reset_n(rst_n),
        .s_axis_valid(s_valid), .s_axis_data(s_data), .s_axis_last(s_last), .s_axis_ready(s_ready),
        .m_axis_valid(m_valid), .m_axis_data(m_data), .m_axis_last(m_last), .m_axis_ready(m_ready),
        .w_wr_en(w_en), .w_wr_addr(w_addr), .w_wr_data(w_data), .w_wr_ready(w_ready),
        .cfg_relu(relu), .busy(busy), .err_len(err_len)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_tests++;
        n_fail++;
        $error("FAIL %s: observed timeout expected handshake", tag);
    endtask

    // Reference: plain dot product, optional ReLU, clamp to the signed 8-bit result range
    function automatic logic signed [63:0] model(input int j, input bit rl);
        longint s = 0;
        for (int i = 0; i < NI; i++) s += longint'(smod[i]) * longint'(wmod[j*NI + i]);
        if (rl && s < 0) s = 0;
        if (s > 127) s = 127;
        if (s < -128) s = -128;
        return s;
    endfunction

    task automatic wr_w(input int a, input int d);
        int g = 0;
        w_en = 1'b1; w_addr = 3'(a); w_data = WW'(d);
        while (!w_ready && g < 100) begin @(negedge clk); g++; end
        if (g >= 100) timeout_fail("w_wr_wait");
        @(negedge clk);
        w_en = 1'b0;
        wmod[a] = d;
    endtask

    task automatic push(input int d, input bit lst, output bit err);
        int g = 0;
        s_valid = 1'b1; s_data = IW'(d); s_last = lst;
        while (!s_ready && g < 200) begin @(negedge clk); g++; end
        if (g >= 200) timeout_fail("s_ready_wait");
        @(negedge clk);
        acc_cyc = cyc;
        err = err_len;
        s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic send_frame(input bit rl, input bit with_last);
        bit e;
        relu = rl;
        for (int k = 0; k < NI; k++) begin
            push(smod[k], with_last && (k == NI - 1), e);
            chk($sformatf("err_len_beat%0d", k), e, (k == NI - 1) ? !with_last : 1'b0);
        end
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic recv_check(input int mode, input bit rl, input string tag);
        int g = 0;
        int k = 0;
        int ci = 0;
        bit r;
        bit stall = 1'b0;
        logic signed [63:0] pd;
        logic pl;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        while (!m_valid && g < 100) begin @(negedge clk); g++; end
        if (g >= 100) timeout_fail({tag, "_valid_wait"});
        else chk({tag, "_latency"}, cyc - acc_cyc, NI * NO);
        g = 0;
        while (k < NO && g < 300) begin
            r = (mode == 0) ? 1'b1 : (mode == 1) ? pat[ci % 4] : 1'($urandom_range(0, 1));
            m_ready = r;
            if (m_valid) begin
                if (stall) begin
                    chk({tag, "_stall_data"}, m_data, pd);
                    chk({tag, "_stall_last"}, m_last, pl);
                end
                chk({tag, "_s_ready_send"}, s_ready, 0);
                if (r) begin
                    chk($sformatf("%s_data%0d", tag, k), m_data, model(k, rl));
                    chk($sformatf("%s_last%0d", tag, k), m_last, (k == NO - 1));
                    k++;
                    stall = 1'b0;
                end else begin
                    stall = 1'b1; pd = m_data; pl = m_last;
                end
                ci++;
            end
            @(negedge clk);
            g++;
        end
        m_ready = 1'b0;
        if (g >= 300) timeout_fail({tag, "_recv"});
        chk({tag, "_valid_after"}, m_valid, 0);
        chk({tag, "_s_ready_after"}, s_ready, 1);
    endtask

    task automatic load_test1_weights();
        for (int a = 0; a < NI; a++) wr_w(a, a + 1);
        for (int a = NI; a < NWT; a++) wr_w(a, -1);
    endtask

    task automatic set_samples_1234();
        for (int i = 0; i < NI; i++) smod[i] = i + 1;
    endtask

    initial begin
        bit e;
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
        w_en = 1'b0; w_addr = '0; w_data = '0; relu = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err_len", err_len, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_ready_edge1", s_ready, 0);
        @(negedge clk);
        chk("rel_ready_edge2", s_ready, 1);

        load_test1_weights();
        set_samples_1234();
        send_frame(1'b0, 1'b1);
        chk("t1_model30", model(0, 1'b0), 30);
        chk("t1_busy", busy, 1);
        recv_check(0, 1'b0, "t1");

        send_frame(1'b1, 1'b1);
        recv_check(0, 1'b1, "t2");

        relu = 1'b0;
        push(1, 1'b0, e);
        chk("t4_err_beat0", e, 0);
        push(2, 1'b1, e);
        chk("t4_err_early_last", e, 1);
        chk("t4_busy_load", busy, 0);
        repeat (12) @(negedge clk);
        chk("t4_no_output", m_valid, 0);
        chk("t4_err_pulse_gone", err_len, 0);
        send_frame(1'b0, 1'b1);
        recv_check(0, 1'b0, "t4b");

        send_frame(1'b0, 1'b0);
        recv_check(0, 1'b0, "nolast");

        send_frame(1'b0, 1'b1);
        recv_check(1, 1'b0, "t5");

        send_frame(1'b0, 1'b1);
        w_en = 1'b1; w_addr = 3'd0; w_data = 8'sd99;
        chk("t6_w_ready_compute", w_ready, 0);
        chk("t6_s_ready_compute", s_ready, 0);
        @(negedge clk);
        chk("t6_w_ready_compute2", w_ready, 0);
        w_en = 1'b0;
        recv_check(0, 1'b0, "t6");

        for (int a = 0; a < NWT; a++) wr_w(a, 127);
        for (int i = 0; i < NI; i++) smod[i] = 127;
        send_frame(1'b0, 1'b1);
        recv_check(0, 1'b0, "t3_pos");
        for (int i = 0; i < NI; i++) smod[i] = -128;
        send_frame(1'b0, 1'b1);
        chk("t3_model_neg", model(1, 1'b0), -128);
        recv_check(0, 1'b0, "t3_neg");

        for (int f = 0; f < 24; f++) begin
            bit big;
            big = 1'($urandom_range(0, 1));
            if (f % 3 == 0) begin
                for (int a = 0; a < NWT; a++)
                    wr_w(a, big ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 7)) - 4);
            end
            for (int i = 0; i < NI; i++)
                smod[i] = big ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 15)) - 8;
            send_frame(1'($urandom_range(0, 1)), 1'b1);
            recv_check(2, relu, $sformatf("rnd%0d", f));
        end

        load_test1_weights();
        set_samples_1234();
        send_frame(1'b0, 1'b1);
        while (!m_valid && cyc - acc_cyc < 100) @(negedge clk);
        chk("t6r_valid_before", m_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("t6r_valid_async", m_valid, 0);
        chk("t6r_busy_async", busy, 0);
        chk("t6r_last_async", m_last, 0);
        chk("t6r_s_ready_async", s_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6r_ready_edge1", s_ready, 0);
        @(negedge clk);
        chk("t6r_ready_edge2", s_ready, 1);
        send_frame(1'b0, 1'b1);
        recv_check(0, 1'b0, "post_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed hang expected finish");
        $fatal(1, "global timeout");
    end

endmodule
